// File: rtl/sipo_msb.sv
// MSB-first serial-to-parallel deserializer; receive side of the piso_msb link.
// A sof strobe frames WIDTH bits; completed words pulse valid, restarted frames pulse err.
module sipo_msb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             sof,
  input  logic             inp,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Pulses default low so they clear on the next edge even while enb is low.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (enb) begin
      case (state_reg)
        IDLE: begin
          if (sof) begin
            shift_next            = '0;
            shift_next[WIDTH-1]   = inp;
            cnt_next              = CNT_START;
            state_next            = SHIFT;
          end
        end
        SHIFT: begin
          if (sof) begin
            // A new sof wins over the pending bit, even the LSB.
            err_next              = 1'b1;
            shift_next            = '0;
            shift_next[WIDTH-1]   = inp;
            cnt_next              = CNT_START;
          end else begin
            shift_next[cnt_reg] = inp;
            if (cnt_reg == '0) begin
              out_next   = {shift_reg[WIDTH-1:1], inp};
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign out   = out_reg;
  assign valid = valid_reg;
  assign err   = err_reg;
  assign busy  = (state_reg == SHIFT);

endmodule

// File: tb/tb_sipo_msb.sv
// Directed bench for sipo_msb: a bit-collecting frame model is checked every cycle,
// plus literal expectations on words, latencies and pulse counts.
module tb_sipo_msb;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enb = 1'b0;
  logic             sof = 1'b0;
  logic             inp = 1'b0;
  logic [WIDTH-1:0] out;
  logic             valid, busy, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [WIDTH-1:0] words[$];

  // Model state: number of bits gathered so far in the open frame.
  int               m_acc = 0;
  int               m_n = 0;
  logic             m_busy = 1'b0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_valid = 1'b0;
  logic             m_err = 1'b0;

  sipo_msb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .enb(enb), .sof(sof), .inp(inp),
    .out(out), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame model: a sof opens a frame, WIDTH collected bits close it.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_acc = 0; m_n = 0; m_busy = 1'b0; m_out = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (enb) begin
        if (sof) begin
          m_err  = m_busy;
          m_acc  = int'(inp);
          m_n    = 1;
          m_busy = 1'b1;
        end else if (m_busy) begin
          m_acc = m_acc * 2 + int'(inp);
          m_n   = m_n + 1;
          if (m_n == WIDTH) begin
            m_out   = WIDTH'(m_acc);
            m_valid = 1'b1;
            m_busy  = 1'b0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("out", int'(out), int'(m_out));
      check("valid", int'(valid), int'(m_valid));
      check("busy", int'(busy), int'(m_busy));
      check("err", int'(err), int'(m_err));
      if (valid) begin
        n_valid++;
        words.push_back(out);
      end
      if (err) n_err++;
      $display("[TB] cyc=%0d sof=%b inp=%b enb=%b out=%h valid=%b busy=%b err=%b",
               cyc, sof, inp, enb, out, valid, busy, err);
    end
  end

  task automatic step(input logic s, input logic b, input logic e);
    @(negedge clk);
    sof = s; inp = b; enb = e;
  endtask

  // Stall cycles carry sof=1/inp=1 to show that enb=0 hides them.
  task automatic frame(input logic [WIDTH-1:0] w, input int stall_pos, input int nstall);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == stall_pos) repeat (nstall) step(1'b1, 1'b1, 1'b0);
      step(i == 0, w[WIDTH-1-i], 1'b1);
      if (i == 0) start_cyc = cyc + 1;
    end
  endtask

  task automatic finish_check(input string name, input logic [WIDTH-1:0] w, input int nstall);
    step(1'b0, 1'b0, 1'b0);
    check({name, "_valid"}, int'(valid), 1);
    check({name, "_out"}, int'(out), int'(w));
    check({name, "_model"}, int'(m_out), int'(w));
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_latency"}, cyc - start_cyc, WIDTH - 1 + nstall);
    step(1'b0, 1'b0, 1'b0);
    check({name, "_valid_clr"}, int'(valid), 0);
  endtask

  initial begin
    int v0, e0;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1);

    // Single frame 4'hB
    frame(4'hB, -1, 0);
    finish_check("b", 4'hB, 0);

    // Back-to-back A then 5
    v0 = n_valid; e0 = n_err;
    frame(4'hA, -1, 0);
    frame(4'h5, -1, 0);
    finish_check("b2b", 4'h5, 0);
    check("b2b_nvalid", n_valid - v0, 2);
    check("b2b_word0", int'(words[words.size()-2]), 'hA);
    check("b2b_word1", int'(words[words.size()-1]), 'h5);
    check("b2b_noerr", n_err - e0, 0);

    // Frame C with a 3-cycle enable gap after the second bit
    frame(4'hC, 2, 3);
    finish_check("stall", 4'hC, 3);

    // Abort after two bits, then frame 6
    e0 = n_err; v0 = n_valid;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    frame(4'h6, -1, 0);
    check("abort_hold", int'(out), 'hC);
    finish_check("abort", 4'h6, 0);
    check("abort_nerr", n_err - e0, 1);
    check("abort_nvalid", n_valid - v0, 1);

    // Async reset mid-frame with non-zero out, then frame 9
    e0 = n_err; v0 = n_valid;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", int'(out), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_err", int'(err), 0);
    #1 rst = 1'b0;
    frame(4'h9, -1, 0);
    finish_check("post_rst", 4'h9, 0);
    check("post_rst_nerr", n_err - e0, 0);
    check("post_rst_nvalid", n_valid - v0, 1);

    repeat (2) step(1'b0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
